// File: rtl/rx_huge_pages_addr_mc.sv
// rx_huge_pages_addr_mc
//   Snoops posted memory-write TLPs on the TRN receive interface for one BAR
//   and decodes a per-page register window. Each page has a 64-bit huge-page
//   bus address and a status bit that tells the RX DMA engine the page has
//   been handed over. Staged address halves are committed on the edge that
//   accepts the EOF beat; discarded or interrupted TLPs leave no trace.
//
//   Register window (16 bytes per page, at BASE_ADDR):
//     +0 ADDR_LO (length 1 or 2), +4 ADDR_HI (length 1), +8 UNLOCK (length 1)
//
//   Optional feature macro: RX_HUGE_PAGES_MWR64_EN
//     defined   : MWr64 (4DW header) writes are decoded as well as MWr32
//     undefined : MWr64 TLPs are drained as unclaimed
//
// Ports
//   trn_clk, reset_n      clock, asynchronous active-low reset
//   trn_rd                RX data beat
//   trn_rrem_n            unused
//   trn_rsof_n/reof_n     start/end of TLP
//   trn_rsrc_rdy_n        source ready (beat valid)
//   trn_rdst_rdy_n        destination ready (observed only, never driven)
//   trn_rsrc_dsc_n        core discard
//   trn_rbar_hit_n        BAR hit vector
//   huge_page_addr        page p address at [64p+63:64p]
//   huge_page_status      1 = page handed to DMA engine
//   huge_page_free        pulse from DMA engine: page consumed
module rx_huge_pages_addr_mc #(
   parameter int          NUM_PAGES = 2,
   parameter int          BAR_NUM   = 2,
   parameter logic [11:0] BASE_ADDR = 12'h000
) (
   input  logic                      trn_clk,
   input  logic                      reset_n,
   input  logic [63:0]               trn_rd,
   input  logic [7:0]                trn_rrem_n,
   input  logic                      trn_rsof_n,
   input  logic                      trn_reof_n,
   input  logic                      trn_rsrc_rdy_n,
   input  logic                      trn_rdst_rdy_n,
   input  logic                      trn_rsrc_dsc_n,
   input  logic [6:0]                trn_rbar_hit_n,
   output logic [64*NUM_PAGES-1:0]   huge_page_addr,
   output logic [NUM_PAGES-1:0]      huge_page_status,
   input  logic [NUM_PAGES-1:0]      huge_page_free
);

   localparam int            PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
   localparam logic [PW:0]   NP = (PW+1)'(NUM_PAGES);
   localparam logic [1:0]    REG_LO     = 2'd0;
   localparam logic [1:0]    REG_HI     = 2'd1;
   localparam logic [1:0]    REG_UNLOCK = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_HDR1, S_DATA, S_DATA2, S_DRAIN} state_t;

   state_t               state_q;
   logic                 is4_q;
   logic                 len2_q;
   logic [PW-1:0]        page_q;
   logic [1:0]           reg_q;
   logic [31:0]          data0_q;
   logic [63:0]          addr_q [NUM_PAGES];
   logic [NUM_PAGES-1:0] status_q;
   logic [NUM_PAGES-1:0] unlock_q;
   logic [NUM_PAGES-1:0] status_d;

   // Payload dwords arrive byte-reversed relative to the address value.
   function automatic logic [31:0] bswap32(input logic [31:0] dw);
      return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
   endfunction

   logic acc, sof, eof, dsc;
   assign acc = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
   assign sof = acc & ~trn_rsof_n;
   assign eof = ~trn_reof_n;
   assign dsc = ~trn_rsrc_dsc_n;

   // SOF beat: header DW0 in [63:32]
   logic       is_mwr32, is_mwr64, claim, len_ok;
   logic [9:0] hdr_len;
   assign hdr_len  = trn_rd[41:32];
   assign is_mwr32 = (trn_rd[62:56] == 7'h40);
`ifdef RX_HUGE_PAGES_MWR64_EN
   assign is_mwr64 = (trn_rd[62:56] == 7'h60);
`else
   assign is_mwr64 = 1'b0;
`endif
   assign claim  = ~trn_rbar_hit_n[BAR_NUM] & (is_mwr32 | is_mwr64);
   assign len_ok = (hdr_len == 10'd1) | (hdr_len == 10'd2);

   // Address beat: 3DW carries it in [63:32], 4DW carries the low dword in [31:0]
   logic [31:0]   hdr_addr;
   logic [PW-1:0] hit_page;
   logic [1:0]    hit_reg;
   logic          decode_ok;
   assign hdr_addr  = is4_q ? trn_rd[31:0] : trn_rd[63:32];
   assign hit_page  = hdr_addr[PW+3:4];
   assign hit_reg   = hdr_addr[3:2];
   assign decode_ok = (hdr_addr[11:PW+4] == BASE_ADDR[11:PW+4]) &&
                      ({1'b0, hit_page} < NP) &&
                      (hit_reg != 2'd3) &&
                      !((hit_reg == REG_UNLOCK) && len2_q);

   // Commit happens on the accepted EOF beat of a well-formed, undiscarded TLP.
   logic                 cm_en;
   logic [PW-1:0]        cm_page;
   logic [1:0]           cm_reg;
   logic [31:0]          cm_d0, cm_d1;
   logic [NUM_PAGES-1:0] cm_sel;
   always_comb begin
      cm_en   = 1'b0;
      cm_page = page_q;
      cm_reg  = reg_q;
      cm_d0   = data0_q;
      cm_d1   = bswap32(trn_rd[63:32]);
      if (acc && eof && trn_rsof_n && !dsc) begin
         case (state_q)
            S_HDR1: if (!is4_q && !len2_q && decode_ok) begin
               cm_en   = 1'b1;
               cm_page = hit_page;
               cm_reg  = hit_reg;
               cm_d0   = bswap32(trn_rd[31:0]);
            end
            S_DATA: begin
               cm_en = 1'b1;
               cm_d0 = bswap32(trn_rd[63:32]);
               cm_d1 = bswap32(trn_rd[31:0]);
            end
            S_DATA2: cm_en = len2_q;
            default: ;
         endcase
      end
      for (int i = 0; i < NUM_PAGES; i++) cm_sel[i] = (cm_page == PW'(i));
   end

   // Pages already handed to the DMA engine are write-protected.
   logic        busy, wr_lo, wr_hi, wr_unlock;
   logic [31:0] hi_val;
   assign busy      = |(cm_sel & status_q);
   assign wr_lo     = cm_en & ~busy & (cm_reg == REG_LO);
   assign wr_hi     = cm_en & ~busy & (((cm_reg == REG_LO) & len2_q) | (cm_reg == REG_HI));
   assign wr_unlock = cm_en & (cm_reg == REG_UNLOCK);
   assign hi_val    = (cm_reg == REG_HI) ? cm_d0 : cm_d1;

   // Unlock takes priority over a same-cycle free.
   assign status_d = (status_q & ~huge_page_free) | unlock_q;

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         is4_q    <= 1'b0;
         len2_q   <= 1'b0;
         page_q   <= '0;
         reg_q    <= '0;
         data0_q  <= '0;
         status_q <= '0;
         unlock_q <= '0;
         for (int i = 0; i < NUM_PAGES; i++) addr_q[i] <= '0;
      end else begin
         status_q <= status_d;
         unlock_q <= wr_unlock ? cm_sel : '0;
         for (int i = 0; i < NUM_PAGES; i++) begin
            if (cm_sel[i] && wr_lo) addr_q[i][31:0]  <= cm_d0;
            if (cm_sel[i] && wr_hi) addr_q[i][63:32] <= hi_val;
         end
         if (acc) begin
            if (sof) begin
               // A SOF always starts a new TLP, abandoning any in flight.
               is4_q  <= is_mwr64;
               len2_q <= (hdr_len == 10'd2);
               if (eof)                         state_q <= S_IDLE;
               else if (claim && len_ok && !dsc) state_q <= S_HDR1;
               else                             state_q <= S_DRAIN;
            end else if (dsc) begin
               state_q <= eof ? S_IDLE : S_DRAIN;
            end else begin
               case (state_q)
                  S_HDR1: begin
                     page_q  <= hit_page;
                     reg_q   <= hit_reg;
                     data0_q <= bswap32(trn_rd[31:0]);
                     if (eof)             state_q <= S_IDLE;
                     else if (!decode_ok) state_q <= S_DRAIN;
                     else if (is4_q)      state_q <= S_DATA;
                     else                 state_q <= S_DATA2;
                  end
                  S_DATA, S_DATA2: state_q <= eof ? S_IDLE : S_DRAIN;
                  S_DRAIN:         if (eof) state_q <= S_IDLE;
                  default:         ;
               endcase
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_PAGES; g++) begin : g_out
      assign huge_page_addr[64*g +: 64] = addr_q[g];
   end
   assign huge_page_status = status_q;

   logic unused_ok;
   assign unused_ok = ^{trn_rrem_n, trn_rbar_hit_n, hdr_addr};

endmodule

// File: tb/tb_rx_huge_pages_addr_mc.sv
module tb_rx_huge_pages_addr_mc;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [63:0]  rd = '0;
   logic [7:0]   rrem_n = '0;
   logic         rsof_n = 1'b1, reof_n = 1'b1;
   logic         src_rdy_n = 1'b1, dst_rdy_n = 1'b0, dsc_n = 1'b1;
   logic [6:0]   bar_n = 7'h7F;
   logic [255:0] hpa;
   logic [3:0]   hps;
   logic [3:0]   hpf = '0;
   logic [63:0]  hpa1;
   logic [0:0]   hps1;
   logic [0:0]   hpf1 = '0;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] BAR_OK  = 7'b1111011;
   localparam logic [6:0] BAR_BAD = 7'b1111110;

   always #5 clk = ~clk;

   rx_huge_pages_addr_mc #(.NUM_PAGES(4), .BAR_NUM(2), .BASE_ADDR(12'h100)) u_dut (
      .trn_clk(clk), .reset_n(reset_n), .trn_rd(rd), .trn_rrem_n(rrem_n),
      .trn_rsof_n(rsof_n), .trn_reof_n(reof_n), .trn_rsrc_rdy_n(src_rdy_n),
      .trn_rdst_rdy_n(dst_rdy_n), .trn_rsrc_dsc_n(dsc_n), .trn_rbar_hit_n(bar_n),
      .huge_page_addr(hpa), .huge_page_status(hps), .huge_page_free(hpf));

   rx_huge_pages_addr_mc #(.NUM_PAGES(1), .BAR_NUM(2), .BASE_ADDR(12'h000)) u_dut1 (
      .trn_clk(clk), .reset_n(reset_n), .trn_rd(rd), .trn_rrem_n(rrem_n),
      .trn_rsof_n(rsof_n), .trn_reof_n(reof_n), .trn_rsrc_rdy_n(src_rdy_n),
      .trn_rdst_rdy_n(dst_rdy_n), .trn_rsrc_dsc_n(dsc_n), .trn_rbar_hit_n(bar_n),
      .huge_page_addr(hpa1), .huge_page_status(hps1), .huge_page_free(hpf1));

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Stall cycles carry garbage with SOF/EOF asserted but no handshake.
   task automatic drive_beat(input logic sof, input logic eof, input logic dsc,
                             input logic [63:0] d, input int stall);
      for (int i = 0; i < stall; i++) begin
         src_rdy_n = 1'b1; rsof_n = 1'b0; reof_n = 1'b0; dsc_n = 1'b0;
         rd = 64'hA5A5_5A5A_F0F0_0F0F;
         @(posedge clk); #1;
      end
      rd = d; rsof_n = ~sof; reof_n = ~eof; dsc_n = ~dsc; src_rdy_n = 1'b0;
      @(posedge clk); #1;
      src_rdy_n = 1'b1; rsof_n = 1'b1; reof_n = 1'b1; dsc_n = 1'b1;
   endtask

   task automatic send_mwr32(input logic [31:0] addr, input logic [9:0] len,
                             input logic [31:0] r0, input logic [31:0] r1,
                             input logic [6:0] bar, input int stall, input logic dsc_eof);
      bar_n = bar;
      drive_beat(1'b1, 1'b0, 1'b0, {1'b0, 7'h40, 14'h0, len, 32'h0000_00FF}, 0);
      if (len <= 10'd1) begin
         drive_beat(1'b0, 1'b1, dsc_eof, {addr, r0}, stall);
      end else begin
         drive_beat(1'b0, 1'b0, 1'b0, {addr, r0}, stall);
         drive_beat(1'b0, 1'b1, dsc_eof, {r1, 32'h0}, stall);
      end
      bar_n = 7'h7F;
   endtask

   task automatic send_mwr64(input logic [31:0] addr, input logic [9:0] len,
                             input logic [31:0] r0, input logic [31:0] r1);
      bar_n = BAR_OK;
      drive_beat(1'b1, 1'b0, 1'b0, {1'b0, 7'h60, 14'h0, len, 32'h0000_00FF}, 0);
      drive_beat(1'b0, 1'b0, 1'b0, {32'h0, addr}, 0);
      drive_beat(1'b0, 1'b1, 1'b0, {r0, r1}, 0);
      bar_n = 7'h7F;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      checks++; if (hpa !== 256'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", hpa); end
      checks++; if (hps !== 4'h0) begin errors++; $display("FAIL reset_status: got %h want 0", hps); end
      checks++; if (hpa1 !== 64'h0) begin errors++; $display("FAIL reset_addr_dut1: got %h want 0", hpa1); end
   endtask

   task automatic test_addr_write();
      bar_n = BAR_OK;
      drive_beat(1'b1, 1'b0, 1'b0, {32'h4000_0002, 32'h0000_00FF}, 0);
      drive_beat(1'b0, 1'b0, 1'b0, {32'h0000_0110, 32'h0000_1000}, 0);
      checks++; if (hpa[127:64] !== 64'h0) begin errors++; $display("FAIL addr_before_eof: got %h want 0", hpa[127:64]); end
      drive_beat(1'b0, 1'b1, 1'b0, {32'h1200_0000, 32'h0}, 0);
      bar_n = 7'h7F;
      checks++; if (hpa[127:64] !== 64'h00000012_00100000) begin errors++; $display("FAIL addr_lo_len2: got %h want 00000012_00100000", hpa[127:64]); end
      checks++; if (hpa[63:0] !== 64'h0 || hpa[255:128] !== 128'h0) begin errors++; $display("FAIL addr_others: got %h want only page1 set", hpa); end
      send_mwr32(32'h124, 10'd1, 32'h7856_3412, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa[191:128] !== 64'h12345678_00000000) begin errors++; $display("FAIL addr_hi_len1: got %h want 12345678_00000000", hpa[191:128]); end
      send_mwr32(32'h120, 10'd1, 32'hEFBE_ADDE, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa[191:128] !== 64'h12345678_DEADBEEF) begin errors++; $display("FAIL addr_lo_len1: got %h want 12345678_DEADBEEF", hpa[191:128]); end
   endtask

   task automatic test_unlock();
      send_mwr32(32'h138, 10'd1, 32'hFFFF_FFFF, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hps[3] !== 1'b0) begin errors++; $display("FAIL unlock_eof_edge: got %b want 0", hps[3]); end
      tick(1);
      checks++; if (hps !== 4'b1000) begin errors++; $display("FAIL unlock_rise: got %b want 1000", hps); end
      tick(4);
      hpf = 4'b1000;
      tick(1);
      hpf = 4'b0000;
      checks++; if (hps[3] !== 1'b0) begin errors++; $display("FAIL free_clear: got %b want 0", hps[3]); end
      send_mwr32(32'h138, 10'd1, 32'h0, 32'h0, BAR_OK, 0, 1'b0);
      hpf = 4'b1000;
      tick(1);
      hpf = 4'b0000;
      checks++; if (hps[3] !== 1'b1) begin errors++; $display("FAIL unlock_vs_free: got %b want 1", hps[3]); end
      tick(1);
      checks++; if (hps[3] !== 1'b1) begin errors++; $display("FAIL unlock_hold: got %b want 1", hps[3]); end
      hpf = 4'b1000;
      tick(1);
      hpf = 4'b0000;
      checks++; if (hps !== 4'b0000) begin errors++; $display("FAIL free_clear2: got %b want 0000", hps); end
   endtask

   task automatic test_protect();
      send_mwr32(32'h108, 10'd1, 32'h0, 32'h0, BAR_OK, 0, 1'b0);
      tick(1);
      checks++; if (hps[0] !== 1'b1) begin errors++; $display("FAIL protect_status: got %b want 1", hps[0]); end
      send_mwr32(32'h100, 10'd2, 32'h4433_2211, 32'h8877_6655, BAR_OK, 0, 1'b0);
      checks++; if (hpa[63:0] !== 64'h0) begin errors++; $display("FAIL protect_drop: got %h want 0", hpa[63:0]); end
      hpf = 4'b0001;
      tick(1);
      hpf = 4'b0000;
      send_mwr32(32'h100, 10'd2, 32'h4433_2211, 32'h8877_6655, BAR_OK, 0, 1'b0);
      checks++; if (hpa[63:0] !== 64'h55667788_11223344) begin errors++; $display("FAIL protect_after_free: got %h want 55667788_11223344", hpa[63:0]); end
   endtask

   task automatic test_stall_discard();
      send_mwr32(32'h130, 10'd2, 32'h0DF0_FECA, 32'hEFBE_AD0B, BAR_OK, 3, 1'b0);
      checks++; if (hpa[255:192] !== 64'h0BADBEEF_CAFEF00D) begin errors++; $display("FAIL stall_write: got %h want 0BADBEEF_CAFEF00D", hpa[255:192]); end
      send_mwr32(32'h130, 10'd2, 32'h1111_1111, 32'h2222_2222, BAR_OK, 3, 1'b1);
      checks++; if (hpa[255:192] !== 64'h0BADBEEF_CAFEF00D) begin errors++; $display("FAIL discard_eof: got %h want 0BADBEEF_CAFEF00D", hpa[255:192]); end
   endtask

   task automatic test_mwr64();
      logic [63:0] exp4, exp3;
`ifdef RX_HUGE_PAGES_MWR64_EN
      exp4 = 64'h00000002_00000001;
      exp3 = 64'h000000AA_00000001;
`else
      exp4 = 64'h12345678_DEADBEEF;
      exp3 = 64'h000000AA_DEADBEEF;
`endif
      send_mwr64(32'h120, 10'd2, 32'h0100_0000, 32'h0200_0000);
      checks++; if (hpa[191:128] !== exp4) begin errors++; $display("FAIL mwr64_write: got %h want %h", hpa[191:128], exp4); end
      send_mwr32(32'h124, 10'd1, 32'hAA00_0000, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa[191:128] !== exp3) begin errors++; $display("FAIL mwr32_after_mwr64: got %h want %h", hpa[191:128], exp3); end
   endtask

   task automatic test_ignored();
      send_mwr32(32'h110, 10'd3, 32'h0101_0101, 32'h0202_0202, BAR_OK, 0, 1'b0);
      send_mwr32(32'h110, 10'd0, 32'h0303_0303, 32'h0, BAR_OK, 0, 1'b0);
      send_mwr32(32'h11C, 10'd1, 32'h0404_0404, 32'h0, BAR_OK, 0, 1'b0);
      send_mwr32(32'h110, 10'd1, 32'h0505_0505, 32'h0, BAR_BAD, 0, 1'b0);
      send_mwr32(32'h210, 10'd1, 32'h0606_0606, 32'h0, BAR_OK, 0, 1'b0);
      send_mwr32(32'h118, 10'd2, 32'h0, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa[127:64] !== 64'h00000012_00100000) begin errors++; $display("FAIL ignored_writes: got %h want 00000012_00100000", hpa[127:64]); end
      tick(2);
      checks++; if (hps !== 4'b0000) begin errors++; $display("FAIL ignored_unlock_len2: got %b want 0000", hps); end
      send_mwr32(32'h114, 10'd1, 32'h0000_0080, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa[127:64] !== 64'h80000000_00100000) begin errors++; $display("FAIL after_ignored: got %h want 80000000_00100000", hpa[127:64]); end
      send_mwr32(32'h010, 10'd1, 32'h0100_0000, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa1 !== 64'h0) begin errors++; $display("FAIL page_out_of_range: got %h want 0", hpa1); end
      send_mwr32(32'h000, 10'd1, 32'h0A00_0000, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa1 !== 64'h00000000_0000000A) begin errors++; $display("FAIL single_page_write: got %h want 0000000A", hpa1); end
   endtask

   task automatic test_back_to_back();
      bar_n = BAR_OK;
      drive_beat(1'b1, 1'b0, 1'b0, {32'h4000_0002, 32'h0000_00FF}, 0);
      drive_beat(1'b0, 1'b0, 1'b0, {32'h0000_0100, 32'hFFFF_FFFF}, 0);
      send_mwr32(32'h100, 10'd1, 32'h7700_0000, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa[63:0] !== 64'h55667788_00000077) begin errors++; $display("FAIL sof_before_eof: got %h want 55667788_00000077", hpa[63:0]); end
      send_mwr32(32'h134, 10'd1, 32'h0100_0000, 32'h0, BAR_OK, 0, 1'b0);
      send_mwr32(32'h130, 10'd1, 32'h0200_0000, 32'h0, BAR_OK, 0, 1'b0);
      checks++; if (hpa[255:192] !== 64'h00000001_00000002) begin errors++; $display("FAIL back_to_back: got %h want 00000001_00000002", hpa[255:192]); end
   endtask

   initial begin
      test_reset();
      test_addr_write();
      test_unlock();
      test_protect();
      test_stall_discard();
      test_mwr64();
      test_ignored();
      test_back_to_back();
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
